// File: rtl/pcw_sdram_arbiter.sv
// Slot-paced arbiter sharing one 8-bit SDRAM port between CPU, DMA and a boot-loader pass-through.
// Optional macro ARB_ROUND_ROBIN_EN: alternate CPU/DMA on ties (default build gives DMA fixed priority).
module pcw_sdram_arbiter #(
   parameter int ADDR_W = 22
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sdram_clk_ref,
   input  logic              sdram_ready,
   input  logic              boot_active,
   input  logic              boot_wr,
   input  logic [15:0]       boot_addr,
   input  logic [7:0]        boot_data,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic              cpu_ack,
   output logic [7:0]        cpu_rdata,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [7:0]        dma_wdata,
   output logic              dma_ack,
   output logic [7:0]        dma_rdata,
   output logic              sdram_we,
   output logic              sdram_oe,
   output logic [ADDR_W-1:0] sdram_addr,
   output logic [7:0]        sdram_din,
   input  logic [7:0]        sdram_dout,
   output logic [1:0]        grant
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_BOOT} state_e;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_CPU  = 2'b01;
   localparam logic [1:0] GNT_DMA  = 2'b10;
   localparam logic [1:0] GNT_BOOT = 2'b11;

   state_e            state_q, state_d;
   logic [1:0]        grant_q, grant_d;
   logic              we_q, we_d;
   logic              oe_q, oe_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        din_q, din_d;
   logic              rd_q, rd_d;
   logic              win_dma_q, win_dma_d;
   logic              cpu_ack_q, cpu_ack_d;
   logic              dma_ack_q, dma_ack_d;
   logic [7:0]        cpu_rdata_q, cpu_rdata_d;
   logic [7:0]        dma_rdata_q, dma_rdata_d;
   logic              ref_last_q;

   logic slot;
   logic tie_dma;
   logic pick_dma;
   logic sel_we;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_dma_q, last_dma_d;

   // On a tie the port that was not served last goes next.
   assign tie_dma = ~last_dma_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         last_dma_q <= 1'b0;
      end else begin
         last_dma_q <= last_dma_d;
      end
   end
`else
   assign tie_dma = 1'b1;
`endif

   assign slot     = sdram_ready & ~ref_last_q & sdram_clk_ref;
   assign pick_dma = dma_req & (~cpu_req | tie_dma);
   assign sel_we   = pick_dma ? dma_we : cpu_we;

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      we_d        = we_q;
      oe_d        = oe_q;
      addr_d      = addr_q;
      din_d       = din_q;
      rd_d        = rd_q;
      win_dma_d   = win_dma_q;
      cpu_ack_d   = 1'b0;
      dma_ack_d   = 1'b0;
      cpu_rdata_d = cpu_rdata_q;
      dma_rdata_d = dma_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
      last_dma_d  = last_dma_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (slot) begin
               if (boot_active) begin
                  state_d = S_BOOT;
                  grant_d = GNT_BOOT;
                  we_d    = 1'b0;
                  oe_d    = 1'b0;
               end else if (cpu_req | dma_req) begin
                  win_dma_d = pick_dma;
                  addr_d    = pick_dma ? dma_addr : cpu_addr;
                  din_d     = pick_dma ? dma_wdata : cpu_wdata;
                  rd_d      = ~sel_we;
                  we_d      = sel_we;
                  oe_d      = ~sel_we;
                  grant_d   = pick_dma ? GNT_DMA : GNT_CPU;
`ifdef ARB_ROUND_ROBIN_EN
                  last_dma_d = pick_dma;
`endif
                  state_d   = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (slot) begin
               we_d    = 1'b0;
               oe_d    = 1'b0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (slot) begin
               if (win_dma_q) begin
                  dma_ack_d = 1'b1;
                  if (rd_q) dma_rdata_d = sdram_dout;
               end else begin
                  cpu_ack_d = 1'b1;
                  if (rd_q) cpu_rdata_d = sdram_dout;
               end
               grant_d = GNT_NONE;
               state_d = S_IDLE;
            end
         end
         S_BOOT: begin
            // Leaving boot is not slot-paced: the loader owns the bus until it lets go.
            if (!boot_active) begin
               state_d = S_IDLE;
               grant_d = GNT_NONE;
               we_d    = 1'b0;
               oe_d    = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         grant_q     <= GNT_NONE;
         we_q        <= 1'b0;
         oe_q        <= 1'b0;
         addr_q      <= '0;
         din_q       <= '0;
         rd_q        <= 1'b0;
         win_dma_q   <= 1'b0;
         cpu_ack_q   <= 1'b0;
         dma_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
         ref_last_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         we_q        <= we_d;
         oe_q        <= oe_d;
         addr_q      <= addr_d;
         din_q       <= din_d;
         rd_q        <= rd_d;
         win_dma_q   <= win_dma_d;
         cpu_ack_q   <= cpu_ack_d;
         dma_ack_q   <= dma_ack_d;
         cpu_rdata_q <= cpu_rdata_d;
         dma_rdata_q <= dma_rdata_d;
         ref_last_q  <= sdram_clk_ref;
      end
   end

   // Boot pass-through bypasses the registered command path entirely.
   assign sdram_we   = (state_q == S_BOOT) ? boot_wr : we_q;
   assign sdram_oe   = (state_q == S_BOOT) ? 1'b0 : oe_q;
   assign sdram_addr = (state_q == S_BOOT) ? ADDR_W'(boot_addr) : addr_q;
   assign sdram_din  = (state_q == S_BOOT) ? boot_data : din_q;
   assign grant      = grant_q;
   assign cpu_ack    = cpu_ack_q;
   assign dma_ack    = dma_ack_q;
   assign cpu_rdata  = cpu_rdata_q;
   assign dma_rdata  = dma_rdata_q;

endmodule

// File: tb/tb_pcw_sdram_arbiter.sv
// Scoreboard bench for pcw_sdram_arbiter: transaction-level model predicts commands, releases and acks.
module tb_pcw_sdram_arbiter;
   localparam int AW = 22;

   logic          clk = 1'b0;
   logic          reset;
   logic          sdram_clk_ref, sdram_ready;
   logic          boot_active, boot_wr;
   logic [15:0]   boot_addr;
   logic [7:0]    boot_data;
   logic          cpu_req, cpu_we, cpu_ack;
   logic [AW-1:0] cpu_addr;
   logic [7:0]    cpu_wdata, cpu_rdata;
   logic          dma_req, dma_we, dma_ack;
   logic [AW-1:0] dma_addr;
   logic [7:0]    dma_wdata, dma_rdata;
   logic          sdram_we, sdram_oe;
   logic [AW-1:0] sdram_addr;
   logic [7:0]    sdram_din, sdram_dout;
   logic [1:0]    grant;

   always #5 clk = ~clk;

   pcw_sdram_arbiter #(.ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .sdram_clk_ref(sdram_clk_ref), .sdram_ready(sdram_ready),
      .boot_active(boot_active), .boot_wr(boot_wr), .boot_addr(boot_addr), .boot_data(boot_data),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ack(dma_ack), .dma_rdata(dma_rdata),
      .sdram_we(sdram_we), .sdram_oe(sdram_oe), .sdram_addr(sdram_addr), .sdram_din(sdram_din),
      .sdram_dout(sdram_dout), .grant(grant)
   );

   typedef struct { int cyc; bit port; bit we; logic [AW-1:0] addr; logic [7:0] din; } cmd_t;
   typedef struct { int cyc; bit port; logic [7:0] crd; logic [7:0] drd; } ack_t;

   cmd_t cmd_q[$];
   int   rel_q[$];
   ack_t ack_q[$];

   int checks = 0;
   int errs   = 0;
   int cyc    = 0;
   bit rst_at_edge = 1'b1;

   // Reference model state: transaction phase counts slots since grant (0 = free).
   bit       m_ref_last = 1'b1;
   int       m_stage = 0;
   bit       m_boot = 0, m_win = 0, m_we = 0, m_last = 0, m_slot = 0;
   bit       m_done[2];
   logic [7:0] m_rd[2];

   bit ref_auto = 0, rand_ref = 0, rand_dout = 0, rand_ready = 0, auto_ag = 0, gen_en = 0;
   bit cpu_pend = 0, dma_pend = 0;
   int ref_cnt = 0, ref_half = 2;

   always @(posedge clk) begin
      cyc         <= cyc + 1;
      rst_at_edge <= reset;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model();
      bit slot, w;
      int e;
      e = cyc + 1;
      m_slot = 0;
      if (reset) begin
         m_stage = 0; m_boot = 0; m_last = 0; m_ref_last = 1;
         m_rd[0] = 8'h00; m_rd[1] = 8'h00;
         cmd_q.delete(); rel_q.delete(); ack_q.delete();
      end else begin
         slot = sdram_ready && !m_ref_last && sdram_clk_ref;
         m_ref_last = sdram_clk_ref;
         m_slot = slot;
         if (m_boot) begin
            if (!boot_active) m_boot = 0;
         end else if (slot) begin
            if (m_stage == 0) begin
               if (boot_active) m_boot = 1;
               else if (cpu_req || dma_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                  if (cpu_req && dma_req) w = (m_last == 0); else w = dma_req;
`else
                  w = dma_req;
`endif
                  cmd_q.push_back('{e, w, w ? dma_we : cpu_we, w ? dma_addr : cpu_addr,
                                    w ? dma_wdata : cpu_wdata});
                  m_win = w; m_we = w ? dma_we : cpu_we; m_last = w; m_stage = 1;
               end
            end else if (m_stage == 1) begin
               rel_q.push_back(e);
               m_stage = 2;
            end else begin
               if (!m_we) m_rd[m_win] = sdram_dout;
               ack_q.push_back('{e, m_win, m_rd[0], m_rd[1]});
               m_done[m_win] = 1;
               m_stage = 0;
            end
         end
      end
   endtask

   task automatic agents();
      if (m_done[0]) begin m_done[0] = 0; cpu_pend = 0; cpu_req = 0; end
      if (m_done[1]) begin m_done[1] = 0; dma_pend = 0; dma_req = 0; end
      if (gen_en && !cpu_pend && $urandom_range(0, 3) == 0) begin
         cpu_pend = 1; cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
         cpu_addr = AW'($urandom); cpu_wdata = 8'($urandom);
      end
      if (gen_en && !dma_pend && $urandom_range(0, 3) == 0) begin
         dma_pend = 1; dma_req = 1; dma_we = 1'($urandom_range(0, 1));
         dma_addr = AW'($urandom); dma_wdata = 8'($urandom);
      end
   endtask

   // Inputs are set at negedge+1; the model predicts the upcoming rising edge.
   task automatic tick();
      if (auto_ag) agents();
      if (ref_auto) begin
         ref_cnt++;
         if (ref_cnt >= ref_half) begin
            ref_cnt = 0;
            sdram_clk_ref = ~sdram_clk_ref;
            if (rand_ref) ref_half = $urandom_range(1, 3);
         end
      end
      if (rand_ready) sdram_ready = ($urandom_range(0, 9) != 0);
      if (rand_dout) sdram_dout = 8'($urandom);
      model();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic wait_done(input int p, input string nm);
      int n = 0;
      while (!m_done[p] && n < 400) begin tick(); n++; end
      chk({nm, "_timeout"}, n < 400, 1);
      m_done[p] = 0;
   endtask

   task automatic wait_stage(input int s, input string nm);
      int n = 0;
      while (m_stage != s && n < 200) begin tick(); n++; end
      chk({nm, "_timeout"}, n < 200, 1);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_grant"}, grant, 0);
      chk({nm, "_we"}, sdram_we, 0);
      chk({nm, "_oe"}, sdram_oe, 0);
      chk({nm, "_addr"}, sdram_addr, 0);
      chk({nm, "_din"}, sdram_din, 0);
      chk({nm, "_cpu_ack"}, cpu_ack, 0);
      chk({nm, "_dma_ack"}, dma_ack, 0);
      chk({nm, "_cpu_rdata"}, cpu_rdata, 0);
      chk({nm, "_dma_rdata"}, dma_rdata, 0);
   endtask

   // Monitor: pops expectations whenever the DUT starts/ends a command or acks.
   initial begin
      bit   act, prev_act;
      cmd_t c;
      ack_t a;
      prev_act = 0;
      forever begin
         @(negedge clk);
         act = (sdram_we === 1'b1 || sdram_oe === 1'b1) && grant !== 2'b11;
         if (!rst_at_edge) begin
            if (act && !prev_act) begin
               chk("cmd_expected", cmd_q.size() > 0, 1);
               if (cmd_q.size() > 0) begin
                  c = cmd_q.pop_front();
                  chk("cmd_cycle", cyc, c.cyc);
                  chk("cmd_grant", grant, c.port ? 2'b10 : 2'b01);
                  chk("cmd_we", sdram_we, c.we);
                  chk("cmd_oe", sdram_oe, !c.we);
                  chk("cmd_addr", sdram_addr, c.addr);
                  chk("cmd_din", sdram_din, c.din);
               end
            end
            if (!act && prev_act) begin
               chk("rel_expected", rel_q.size() > 0, 1);
               if (rel_q.size() > 0) chk("rel_cycle", cyc, rel_q.pop_front());
            end
            if (cpu_ack !== 1'b0 || dma_ack !== 1'b0) begin
               chk("ack_expected", ack_q.size() > 0, 1);
               if (ack_q.size() > 0) begin
                  a = ack_q.pop_front();
                  chk("ack_cycle", cyc, a.cyc);
                  chk("ack_port", {dma_ack, cpu_ack}, a.port ? 2'b10 : 2'b01);
                  chk("ack_cpu_rdata", cpu_rdata, a.crd);
                  chk("ack_dma_rdata", dma_rdata, a.drd);
               end
            end
         end
         prev_act = act;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] tie_exp [4];
      int n, nslot;
      reset = 1; sdram_clk_ref = 1; sdram_ready = 1;
      boot_active = 0; boot_wr = 0; boot_addr = '0; boot_data = '0;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
      sdram_dout = '0;
      m_rd[0] = 0; m_rd[1] = 0; m_done[0] = 0; m_done[1] = 0;

      // Reset state, and a high reference at release must not count as a slot.
      repeat (3) tick();
      reset = 0;
      chk_zero("rst");
      dma_req = 1; dma_we = 0; dma_addr = 22'h2ABCDE; sdram_dout = 8'hA7;
      repeat (4) tick();
      chk("refhi_no_slot", grant, 0);
      ref_auto = 1; ref_half = 2;
      wait_done(1, "first");
      chk("first_ack", dma_ack, 1);
      chk("first_rdata", dma_rdata, 8'hA7);
      dma_req = 0;
      tick();

      // Boot pass-through and unslotted exit.
      boot_active = 1;
      n = 0;
      while (!m_boot && n < 50) begin tick(); n++; end
      chk("boot_grant", grant, 2'b11);
      boot_wr = 1; boot_addr = 16'h0005; boot_data = 8'hC3;
      #1;
      chk("boot_we", sdram_we, 1);
      chk("boot_oe", sdram_oe, 0);
      chk("boot_addr", sdram_addr, 22'h000005);
      chk("boot_din", sdram_din, 8'hC3);
      tick();
      boot_wr = 0;
      #1;
      chk("boot_we_pulse_end", sdram_we, 0);
      ref_auto = 0;
      boot_active = 0;
      tick();
      chk("boot_exit_grant", grant, 0);
      chk("boot_exit_we", sdram_we, 0);

      // CPU read; boot raised mid-transaction must not disturb it.
      ref_auto = 1;
      cpu_req = 1; cpu_we = 0; cpu_addr = 22'h012345; sdram_dout = 8'h5A;
      wait_stage(1, "rd_issue");
      chk("rd_oe", sdram_oe, 1);
      boot_active = 1;
      wait_done(0, "rd");
      chk("rd_ack", cpu_ack, 1);
      chk("rd_rdata", cpu_rdata, 8'h5A);
      cpu_req = 0; boot_active = 0;
      tick();
      chk("rd_ack_pulse", cpu_ack, 0);
      chk("rd_rdata_hold", cpu_rdata, 8'h5A);

      // Tie with both requests held.
`ifdef ARB_ROUND_ROBIN_EN
      tie_exp[0] = 2'b10; tie_exp[1] = 2'b01; tie_exp[2] = 2'b10; tie_exp[3] = 2'b01;
`else
      tie_exp[0] = 2'b10; tie_exp[1] = 2'b10; tie_exp[2] = 2'b10; tie_exp[3] = 2'b10;
`endif
      cpu_req = 1; cpu_we = 1; cpu_addr = 22'h000111; cpu_wdata = 8'h11;
      dma_req = 1; dma_we = 1; dma_addr = 22'h000222; dma_wdata = 8'h22;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         while (!(m_done[0] || m_done[1]) && n < 200) begin tick(); n++; end
         chk($sformatf("tie_ack%0d", i), {dma_ack, cpu_ack}, tie_exp[i]);
         m_done[0] = 0; m_done[1] = 0;
      end
      cpu_req = 0; dma_req = 0;
      tick();
      chk("tie_rdata_untouched", cpu_rdata, 8'h5A);

      // Ready dropped while a write is in ISSUE.
      cpu_req = 1; cpu_we = 1; cpu_addr = 22'h3F0F0F; cpu_wdata = 8'h96;
      wait_stage(1, "frz_issue");
      sdram_ready = 0;
      repeat (40) tick();
      chk("frz_we", sdram_we, 1);
      chk("frz_ack", cpu_ack, 0);
      chk("frz_grant", grant, 2'b01);
      sdram_ready = 1;
      nslot = 0; n = 0;
      while (!m_done[0] && n < 100) begin tick(); nslot += int'(m_slot); n++; end
      m_done[0] = 0;
      chk("frz_slots", nslot, 2);
      chk("frz_done_ack", cpu_ack, 1);
      cpu_req = 0;
      tick();

      // Reset during WAIT of a DMA write.
      dma_req = 1; dma_we = 1; dma_addr = 22'h155555; dma_wdata = 8'h3C;
      wait_stage(2, "rstw_wait");
      ref_auto = 0; sdram_clk_ref = 1; reset = 1;
      tick();
      reset = 0;
      chk_zero("rstw");
      repeat (5) tick();
      chk("rstw_refhi_no_slot", grant, 0);
      chk("rstw_no_ack", dma_ack, 0);
      ref_auto = 1; ref_cnt = 0;
      wait_done(1, "rstw_after");
      chk("rstw_after_ack", dma_ack, 1);
      dma_req = 0;
      tick();

      // Randomized traffic with random slot spacing, ready drops and read data.
      auto_ag = 1; gen_en = 1; rand_ref = 1; rand_dout = 1; rand_ready = 1;
      repeat (4000) tick();
      gen_en = 0; rand_ready = 0; sdram_ready = 1;
      repeat (300) tick();
      chk("drain_cmd", cmd_q.size(), 0);
      chk("drain_rel", rel_q.size(), 0);
      chk("drain_ack", ack_q.size(), 0);
      chk("drain_grant", grant, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errs);
      $finish;
   end
endmodule

// File: doc/pcw_sdram_arbiter.md
PCW_SDRAM_ARBITER -- requirements
Module: pcw_sdram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 22, SDRAM byte-address width.
REQ-002 SHALL have ports as listed below, with clock and reset first:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- sdram_clk_ref  in  1  SDRAM slot reference.
- sdram_ready  in  1  SDRAM initialised.
- boot_active, boot_wr  in  1 each  boot-loader pass-through enable and write strobe.
- boot_addr  in  16  boot-loader address.
- boot_data  in  8  boot-loader write data.
- cpu_req, cpu_we  in  1 each  CPU request level and write select.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_ack  out  1  CPU completion pulse.
- cpu_rdata  out  8  CPU read data.
- dma_req, dma_we, dma_addr, dma_wdata, dma_ack, dma_rdata  same widths and directions as the cpu_ equivalents.
- sdram_we, sdram_oe  out  1 each  SDRAM write and read command.
- sdram_addr  out  ADDR_W  SDRAM address.
- sdram_din  out  8  SDRAM write data.
- sdram_dout  in  8  SDRAM read data.
- grant  out  2  current owner: 00 none, 01 cpu, 10 dma, 11 boot.

Function
REQ-003 SHALL register sdram_clk_ref into ref_last; a slot is one clk cycle where sdram_ready & ~ref_last & sdram_clk_ref.
REQ-004 SHALL implement states IDLE, ISSUE, WAIT and BOOT; it SHALL act only on slot cycles, except the BOOT exit and reset.
REQ-005 IDLE, slot, boot_active=1: SHALL go to BOOT with grant=11; boot_active takes precedence over all requests.
REQ-006 BOOT: SHALL drive sdram_we=boot_wr, sdram_oe=0, sdram_addr=zero-extended boot_addr and sdram_din=boot_data combinationally.
REQ-007 BOOT: SHALL return to IDLE on the first clk cycle with boot_active=0, not waiting for a slot, with grant=00 and sdram_we=0.
REQ-008 IDLE, slot, no boot, any req: SHALL select a winner per REQ-015 and latch its addr, we and wdata into sdram_addr/sdram_din. It SHALL assert sdram_we (write) or sdram_oe (read), set grant and go to ISSUE.
REQ-009 ISSUE, slot: SHALL deassert sdram_we/sdram_oe and go to WAIT; sdram_addr and sdram_din SHALL be held.
REQ-010 WAIT, slot: SHALL pulse the winner's ack for exactly one clk and go to IDLE with grant=00.
REQ-011 WAIT, slot, read: SHALL load sdram_dout into the winner's rdata in the same cycle as the ack.
REQ-012 rdata SHALL hold its value until that port's next read completes; writes SHALL NOT alter rdata.
REQ-013 A request occupies three slot edges: issue, release, complete. ack SHALL never precede the third edge.
REQ-014 Requesters hold req, we, addr and wdata stable until ack. A req deasserted before ack is a protocol violation and the outcome is unspecified. A req still high in the cycle after ack SHALL be a new request.
REQ-015 CPU and DMA both requesting in IDLE: DMA wins (see REQ-019); a sole requester always wins.
REQ-016 sdram_ready=0 SHALL freeze the state machine; outputs SHALL hold, including an asserted sdram_we/oe in ISSUE.
REQ-017 boot_active asserting during ISSUE or WAIT SHALL have no effect until the transaction completes and IDLE sees a slot.

Reset
REQ-018 reset=1 at a clk edge SHALL, on the next cycle and regardless of state, set:
- state=IDLE, grant=00;
- sdram_we=0, sdram_oe=0, sdram_addr=0, sdram_din=0;
- cpu_ack=dma_ack=0, cpu_rdata=dma_rdata=00h;
- ref_last=1, so a high sdram_clk_ref at reset release is not a slot;
- last_served=cpu.
An in-flight transaction is abandoned without ack.

Configuration
REQ-019 Macro ARB_ROUND_ROBIN_EN:
- Defined: on a CPU/DMA tie the port other than last_served SHALL win; last_served updates at each grant.
- Undefined: on a tie DMA SHALL always win, and last_served is absent.
- Both builds: DMA wins the first tie after reset.

Verification
REQ-020 Boot pass-through: boot_active=1, boot_wr pulse, boot_addr=0005h, boot_data=C3h -> sdram_we=1, sdram_addr=000005h, sdram_din=C3h, grant=11. Deassert boot_active -> IDLE, grant=00.
REQ-021 CPU read: cpu_req=1, cpu_we=0, cpu_addr=012345h, sdram_dout=5Ah at the third slot -> sdram_oe high from slot 1 to slot 2, cpu_ack single pulse at slot 3, cpu_rdata=5Ah.
REQ-022 Tie: cpu_req and dma_req both held:
- RR build: grants dma, cpu, dma, cpu.
- Fixed build: grants dma, dma, dma; cpu never acked while dma_req is held.
REQ-023 sdram_ready dropped in ISSUE for 10 slots -> sdram_we stays 1 and no ack. Ready restored -> completes two slots later.
REQ-024 reset during WAIT of a DMA write -> no dma_ack, all outputs zero next cycle. sdram_clk_ref high at release -> no slot until the next rising edge.
